// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: one-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;

  assign accept = in_valid && in_ready_q;
  assign shamt  = b[SHAMT_W-1:0];

  function automatic logic is_shift(input logic [3:0] code);
    return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    return (code <= OP_SLTU) || is_shift(code);
  endfunction

  // Single-cycle result for every legal code handled outside the iterative shifter.
  function automatic logic [WIDTH-1:0] compute(input logic [3:0] code,
                                               input logic [WIDTH-1:0] op_a,
                                               input logic [WIDTH-1:0] op_b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (code)
      OP_ADD:  r = op_a + op_b;
      OP_SUB:  r = op_a - op_b;
      OP_AND:  r = op_a & op_b;
      OP_OR:   r = op_a | op_b;
      OP_XOR:  r = op_a ^ op_b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  r = op_a << op_b[SHAMT_W-1:0];
      OP_SRL:  r = op_a >> op_b[SHAMT_W-1:0];
      OP_SRA:  r = $signed(op_a) >>> op_b[SHAMT_W-1:0];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]         code_q, code_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_step;

  // sra replicates the current MSB, which is always the original operand's sign bit.
  always_comb begin
    shift_step = shreg_q;
    case (code_q)
      OP_SLL:  shift_step = {shreg_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, shreg_q[WIDTH-1:1]};
      OP_SRA:  shift_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shift_step = shreg_q;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_BARREL_SHIFT_EN
          state_d = DONE;
`else
          if (is_shift(alu_control) && (shamt != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
`endif
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake flags are registered copies of the next-state decode.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath: result/flags only change on the cycle that enters DONE.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
    code_d    = code_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
          code_d = alu_control;
          if (is_shift(alu_control)) begin
            shreg_d = a;
            cnt_d   = shamt;
            if (shamt == '0) begin
              result_d  = a;
              zero_d    = (a == '0);
              illegal_d = 1'b0;
            end
          end else
`endif
          begin
            result_d  = compute(alu_control, a, b);
            zero_d    = (compute(alu_control, a, b) == '0);
            illegal_d = !is_legal(alu_control);
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: begin
        shreg_d = shift_step;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = shift_step;
          zero_d    = (shift_step == '0);
          illegal_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      code_q    <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_BARREL_SHIFT_EN
      code_q    <= code_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases then random ops vs. a reference model.
module tb_alu_multicycle;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] code,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    int sh;
    logic [WIDTH-1:0] ones;
    sh   = int'(y[4:0]);
    ones = '1;
    case (code)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return (signed'(x) < signed'(y)) ? 1 : 0;
      4'd6:  return (x < y) ? 1 : 0;
      4'd8:  return x << sh;
      4'd9:  return x >> sh;
      4'd10: return (x >> sh) | (x[WIDTH-1] ? ~(ones >> sh) : '0);
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] code, input logic [WIDTH-1:0] y);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (code >= 4'd8 && code <= 4'd10) ? int'(y[4:0]) + 1 : 1;
`endif
  endfunction

  // Run one operation, optionally stall the consumer for `hold` cycles, then retire it.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input int hold);
    logic [WIDTH-1:0] exp_r;
    logic             exp_ill;
    int               cycles;
    bit               ready_low_ok;
    exp_r   = ref_result(code, x, y);
    exp_ill = !((code <= 4'd6) || (code >= 4'd8 && code <= 4'd10));
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, WIDTH'(in_ready), WIDTH'(1));
    in_valid = 1'b1; alu_control = code; a = x; b = y; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
    cycles = 1;
    ready_low_ok = 1'b1;
    while (!out_valid && cycles < 100) begin
      if (in_ready) ready_low_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_latency"}, WIDTH'(cycles), WIDTH'(ref_latency(code, y)));
    chk({tag, "_busy_ready_low"}, WIDTH'(ready_low_ok & !in_ready), WIDTH'(1));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_zero"}, WIDTH'(zero), WIDTH'(exp_r == '0));
    chk({tag, "_illegal"}, WIDTH'(illegal), WIDTH'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; alu_control = 4'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, WIDTH'(out_valid), WIDTH'(1));
      chk({tag, "_hold_result"}, result, exp_r);
      chk({tag, "_hold_no_accept"}, WIDTH'(in_ready), WIDTH'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_retire_valid"}, WIDTH'(out_valid), WIDTH'(0));
    chk({tag, "_retire_ready"}, WIDTH'(in_ready), WIDTH'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_control = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", WIDTH'(zero), WIDTH'(0));
    chk("rst_illegal", WIDTH'(illegal), WIDTH'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

    run_op("add_wrap", 4'b0000, 32'h0000_0005, 32'hFFFF_FFFB, 0);
    run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sra4", 4'b1010, 32'h8000_0000, 32'd4, 0);
    run_op("sll0", 4'b1000, 32'h1, 32'h20, 0);
    run_op("srl31", 4'b1001, 32'h8000_0000, 32'd31, 0);
    run_op("backpressure", 4'b0100, 32'h1234_5678, 32'h0F0F_0F0F, 3);
    run_op("inv7", 4'b0111, 32'hDEAD_BEEF, 32'h1, 0);
    run_op("inv12", 4'b1100, 32'hDEAD_BEEF, 32'h3, 1);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b1000; a = 32'h0000_0003; b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("midrst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("midrst_illegal", WIDTH'(illegal), WIDTH'(0));
    run_op("post_rst_add", 4'b0000, 32'h0000_0010, 32'h0000_0020, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0]       rc;
      logic [WIDTH-1:0] ra, rb;
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) rb = WIDTH'($urandom_range(0, 3));
      run_op($sformatf("rand%0d_op%0d", k, rc), rc, ra, rb, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution-side consumer of the control unit's 4-bit ALU control code: takes operands plus ALUControl, returns a 32-bit result and flags.
- Simple ops complete in one cycle. Shifts run iteratively, one bit per cycle, to keep area down in the multi-cycle datapath.
- Sits between the register-file/immediate operand muxes and the writeback/branch logic; valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width; shamt = b[SHAMT_W-1:0]

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and code presented
- in_ready  output  1  block can accept an operation (high only in IDLE)
- alu_control  input  4  operation code (encoding below)
- a  input  WIDTH  operand A (rs1)
- b  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- illegal  output  1  code was not in the encoding table

Behaviour:
- Encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 invalid, 1000 sll, 1001 srl, 1010 sra. 1011-1111 are also invalid.
- States: IDLE, SHIFT, DONE.
- Accept: occurs when in_valid && in_ready. a, b and alu_control are captured; inputs are ignored at all other times.
- Non-shift or invalid code from IDLE:
  - Compute; go to DONE next cycle.
  - out_valid is asserted the cycle after accept (latency 1).
- Shift code from IDLE:
  - Load a into the shift register; counter = shamt.
  - shamt == 0: go to DONE next cycle, result = a.
  - shamt > 0: go to SHIFT. Each SHIFT cycle shifts one position and decrements the counter.
  - On the cycle the counter goes 1->0, go to DONE. out_valid appears shamt+1 cycles after accept.
- Shift fill rules: sll fills zeros at LSB; srl fills zeros at MSB; sra replicates the original bit WIDTH-1.
- Arithmetic: add/sub are modulo 2^WIDTH, with no overflow flag. slt/sltu return 1 or 0 zero-extended to WIDTH.
- Invalid code: result = 0, illegal = 1, zero = 1, latency 1.
- DONE:
  - out_valid = 1; result, zero and illegal are held stable until out_ready.
  - out_valid && out_ready: go to IDLE next cycle.
  - No new accept in the same cycle; in_ready rises the following cycle.
- in_ready = (state == IDLE). No input is accepted during SHIFT or DONE.
- Reset (asynchronous, any state, including mid-shift):
  - state = IDLE; out_valid = 0; result = 0; zero = 0; illegal = 0; counter = 0.
  - in_ready = 1 after reset deasserts.
- Outputs are registered. result/zero/illegal are only meaningful while out_valid = 1, but must be glitch-free and hold their last values otherwise.

Optional Feature:
- ALU_BARREL_SHIFT_EN defined:
  - Shifts use a combinational barrel shifter and complete with latency 1, like the other ops.
  - The SHIFT state and counter are removed.
- Not defined: the iterative shifter described above is used; latency is shamt+1.
- Handshake and result values are identical in both builds.

Test Plan:
- add a=0x0000_0005, b=0xFFFF_FFFB, code 0000 -> out_valid 1 cycle after accept, result 0x0, zero=1, illegal=0.
- slt a=0xFFFF_FFFF, b=0x1, code 0101 -> result 1. Same operands with sltu (0110) -> result 0.
- sra a=0x8000_0000, b=4, code 1010 -> out_valid 5 cycles after accept (1 cycle with ALU_BARREL_SHIFT_EN), result 0xF800_0000. in_ready low throughout.
- sll a=0x1, b=0x20 (shamt=0) -> latency 1, result 0x1. srl a=0x8000_0000, b=31 -> result 0x1 after 32 cycles.
- Backpressure: out_ready held low 3 cycles in DONE with in_valid high and new operands changing -> result stable, no accept. out_ready high -> in_ready high the next cycle.
- Code 0111, then code 1100 -> illegal=1, result 0. Then assert rst mid-shift (sll, shamt=20, after 6 cycles) -> out_valid=0, result=0, in_ready=1 immediately after release; the next add completes normally.
